// File: rtl/wb_port_arbiter_if.sv
// Write-port bus between requesters A/B and the register-file write port.
// The slave modport is the arbiter side; the master modport is the requester/observer side.
interface wb_port_arbiter_if #(
  parameter int WIDTH     = 32,
  parameter int ADD_WIDTH = 5
) ();
  logic                 a_valid;
  logic [ADD_WIDTH-1:0] a_address;
  logic [WIDTH-1:0]     a_data;
  logic                 a_ready;
  logic                 b_valid;
  logic [ADD_WIDTH-1:0] b_address;
  logic [WIDTH-1:0]     b_data;
  logic                 b_ready;
  logic                 wb_write_enable;
  logic [ADD_WIDTH-1:0] wb_address;
  logic [WIDTH-1:0]     wb_data;
  logic                 wb_source;

  modport slave (
    input  a_valid, a_address, a_data, b_valid, b_address, b_data,
    output a_ready, b_ready, wb_write_enable, wb_address, wb_data, wb_source
  );

  modport master (
    output a_valid, a_address, a_data, b_valid, b_address, b_data,
    input  a_ready, b_ready, wb_write_enable, wb_address, wb_data, wb_source
  );
endinterface

// File: rtl/wb_port_arbiter.sv
// Two-requester arbiter onto one register-file write port; latency 1, one acceptance per cycle.
// A beats B; B waits while READY is low. Define WB_AGING_EN to force-grant B after MAX_WAIT lost cycles.
module wb_port_arbiter #(
  parameter int WIDTH     = 32,
  parameter int ADD_WIDTH = 5,
  parameter int MAX_WAIT  = 4
) (
  input  logic                i_clk,
  input  logic                i_rst,
  wb_port_arbiter_if.slave    bus
);

  logic                 w_force_b;
  logic                 w_a_ready;
  logic                 w_b_ready;
  logic                 w_accept;
  logic [ADD_WIDTH-1:0] w_sel_address;
  logic [WIDTH-1:0]     w_sel_data;
  logic                 w_write;

  logic                 r_we;
  logic [ADD_WIDTH-1:0] r_address;
  logic [WIDTH-1:0]     r_data;
  logic                 r_source;

`ifdef WB_AGING_EN
  logic [3:0] r_age;

  assign w_force_b = bus.b_valid && (r_age == 4'(MAX_WAIT));

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_age <= 4'd0;
    end else if (bus.b_valid && !w_b_ready) begin
      r_age <= r_age + 4'd1;
    end else begin
      r_age <= 4'd0;
    end
  end
`else
  assign w_force_b = 1'b0;
`endif

  // Both readies are held low throughout reset so nothing is accepted into a cleared pipeline.
  always_comb begin
    w_a_ready     = !i_rst && bus.a_valid && !w_force_b;
    w_b_ready     = !i_rst && bus.b_valid && !w_a_ready;
    w_accept      = w_a_ready || w_b_ready;
    w_sel_address = w_b_ready ? bus.b_address : bus.a_address;
    w_sel_data    = w_b_ready ? bus.b_data    : bus.a_data;
    w_write       = w_accept && (w_sel_address != '0);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_we      <= 1'b0;
      r_address <= '0;
      r_data    <= '0;
      r_source  <= 1'b0;
    end else begin
      r_we <= w_write;
      if (w_write) begin
        r_address <= w_sel_address;
        r_data    <= w_sel_data;
        r_source  <= w_b_ready;
      end
    end
  end

  assign bus.a_ready         = w_a_ready;
  assign bus.b_ready         = w_b_ready;
  assign bus.wb_write_enable = r_we;
  assign bus.wb_address      = r_address;
  assign bus.wb_data         = r_data;
  assign bus.wb_source       = r_source;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed self-checking bench for wb_port_arbiter; checks reset, priority, address-0, reset abort
// and, when WB_AGING_EN is defined, forced B grant after MAX_WAIT lost cycles.
module tb_wb_port_arbiter;
  logic clk;
  logic rst;
  int   checks;
  int   failures;

  wb_port_arbiter_if #(.WIDTH(32), .ADD_WIDTH(5)) bus ();

  wb_port_arbiter #(.WIDTH(32), .ADD_WIDTH(5), .MAX_WAIT(4)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int b_grants;
    logic exp_a [6];
    logic exp_b [6];
    checks   = 0;
    failures = 0;
    rst = 1'b1;
    bus.a_valid = 1'b1; bus.a_address = 5'd4; bus.a_data = 32'h1111;
    bus.b_valid = 1'b1; bus.b_address = 5'd6; bus.b_data = 32'h2222;
    tick();
    tick();
    chk("rst_we",      32'(bus.wb_write_enable), 32'd0);
    chk("rst_addr",    32'(bus.wb_address),      32'd0);
    chk("rst_data",    bus.wb_data,              32'd0);
    chk("rst_src",     32'(bus.wb_source),       32'd0);
    chk("rst_a_ready", 32'(bus.a_ready),         32'd0);
    chk("rst_b_ready", 32'(bus.b_ready),         32'd0);
    bus.a_valid = 1'b0;
    bus.b_valid = 1'b0;
    rst = 1'b0;

    // Single A write, first edge after reset release
    bus.a_valid = 1'b1; bus.a_address = 5'd5; bus.a_data = 32'hDEAD_BEEF;
    #1;
    chk("a_only_a_ready", 32'(bus.a_ready), 32'd1);
    chk("a_only_b_ready", 32'(bus.b_ready), 32'd0);
    tick();
    bus.a_valid = 1'b0;
    #1;
    chk("a_only_we",   32'(bus.wb_write_enable), 32'd1);
    chk("a_only_addr", 32'(bus.wb_address),      32'd5);
    chk("a_only_data", bus.wb_data,              32'hDEAD_BEEF);
    chk("a_only_src",  32'(bus.wb_source),       32'd0);
    chk("a_drop_ready", 32'(bus.a_ready),        32'd0);
    tick();
    chk("idle_we",   32'(bus.wb_write_enable), 32'd0);
    chk("idle_addr", 32'(bus.wb_address),      32'd5);

    // A and B collide on address 3
    bus.a_valid = 1'b1; bus.a_address = 5'd3; bus.a_data = 32'd1;
    bus.b_valid = 1'b1; bus.b_address = 5'd3; bus.b_data = 32'd2;
    #1;
    chk("col_a_ready", 32'(bus.a_ready), 32'd1);
    chk("col_b_ready", 32'(bus.b_ready), 32'd0);
    tick();
    bus.a_valid = 1'b0;
    #1;
    chk("col_n1_we",   32'(bus.wb_write_enable), 32'd1);
    chk("col_n1_data", bus.wb_data,              32'd1);
    chk("col_n1_src",  32'(bus.wb_source),       32'd0);
    chk("col_b_ready2", 32'(bus.b_ready),        32'd1);
    tick();
    bus.b_valid = 1'b0;
    #1;
    chk("col_n2_we",   32'(bus.wb_write_enable), 32'd1);
    chk("col_n2_addr", 32'(bus.wb_address),      32'd3);
    chk("col_n2_data", bus.wb_data,              32'd2);
    chk("col_n2_src",  32'(bus.wb_source),       32'd1);
    tick();
    chk("col_idle_we", 32'(bus.wb_write_enable), 32'd0);

    // B to address 0: accepted but not written
    bus.b_valid = 1'b1; bus.b_address = 5'd0; bus.b_data = 32'h77;
    #1;
    chk("z_b_ready", 32'(bus.b_ready), 32'd1);
    tick();
    bus.b_valid = 1'b0;
    #1;
    chk("z_we",   32'(bus.wb_write_enable), 32'd0);
    chk("z_addr", 32'(bus.wb_address),      32'd3);
    chk("z_data", bus.wb_data,              32'd2);
    chk("z_src",  32'(bus.wb_source),       32'd1);

    // Reset right after an A acceptance
    bus.a_valid = 1'b1; bus.a_address = 5'd9; bus.a_data = 32'h1234;
    tick();
    bus.a_valid = 1'b0;
    #1;
    chk("ra_we_pre", 32'(bus.wb_write_enable), 32'd1);
    rst = 1'b1;
    #1;
    chk("ra_we",   32'(bus.wb_write_enable), 32'd0);
    chk("ra_addr", 32'(bus.wb_address),      32'd0);
    chk("ra_data", bus.wb_data,              32'd0);
    chk("ra_src",  32'(bus.wb_source),       32'd0);
    tick();
    rst = 1'b0;
    tick();
    chk("ra_post_we",   32'(bus.wb_write_enable), 32'd0);
    chk("ra_post_data", bus.wb_data,              32'd0);

    // Continuous contention
    bus.a_valid = 1'b1; bus.a_address = 5'd7; bus.a_data = 32'hA;
    bus.b_valid = 1'b1; bus.b_address = 5'd8; bus.b_data = 32'hB;
`ifdef WB_AGING_EN
    exp_a = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    exp_b = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    #1;
    for (int k = 0; k < 6; k++) begin
      chk($sformatf("age_a_ready_%0d", k), 32'(bus.a_ready), 32'(exp_a[k]));
      chk($sformatf("age_b_ready_%0d", k), 32'(bus.b_ready), 32'(exp_b[k]));
      if (k == 5) begin
        chk("age_wb_src",  32'(bus.wb_source),  32'd1);
        chk("age_wb_addr", 32'(bus.wb_address), 32'd8);
        chk("age_wb_data", bus.wb_data,         32'hB);
      end
      tick();
    end
`else
    exp_a = '{default: 1'b1};
    exp_b = '{default: 1'b0};
    b_grants = 0;
    #1;
    for (int k = 0; k < 20; k++) begin
      if (bus.b_ready) b_grants++;
      chk($sformatf("strict_a_ready_%0d", k), 32'(bus.a_ready), 32'(exp_a[k % 6]));
      tick();
    end
    chk("strict_b_grants", 32'(b_grants),      32'd0);
    chk("strict_wb_src",   32'(bus.wb_source), 32'(exp_b[0]));
`endif
    bus.a_valid = 1'b0;
    bus.b_valid = 1'b0;
    tick();
    chk("end_idle_we", 32'(bus.wb_write_enable), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
